// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the encoder and the decoder.
package instr_pkg;

  localparam int INST_W = 16;

  // Field positions inside the 16-bit instruction word
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int FLAG_BIT = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = 5;
  localparam int RB_MSB   = 4;
  localparam int RB_LSB   = 2;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  // Instruction format selector
  localparam logic FMT_REG = 1'b0;
  localparam logic FMT_IMM = 1'b1;

endpackage

// File: rtl/instr_fifo.sv
// Parameterised synchronous FIFO: push/pop with registered count, full and empty.
// Head word is presented combinationally from the read pointer.
module instr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Guard against push-when-full and pop-when-empty so callers cannot corrupt state
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state: storage write, pointer advance (natural wrap at DEPTH), occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field sets into 16-bit words, buffers them in a
// small FIFO and emits them on the inst/inst_wr write interface through a
// registered output stage.
//
// Handshake: a field set is accepted on a rising edge where in_valid && in_ready;
// in_ready is high whenever the FIFO is not full and does not depend on in_valid.
// The consumer side has no ready: out_stall = 1 suppresses the pop for that cycle,
// otherwise a word is emitted whenever the FIFO holds one (inst_wr is a one-cycle strobe).
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_fmt,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic              in_flag,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [7:0]        in_imm,
  input  logic              out_stall,
  output logic [INST_W-1:0] inst,
  output logic              inst_wr,
  output logic [PTR_W:0]    fifo_count,
  output logic [CNT_W-1:0]  enc_count
);

  logic [INST_W-1:0] packed_word;
  logic [INST_W-1:0] head_word;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_wr_q, inst_wr_d;
  logic [CNT_W-1:0]  enc_cnt_q, enc_cnt_d;

  // Pack the field set; unused fields of each form are dropped so they cannot leak X
  always_comb begin
    packed_word                   = '0;
    packed_word[OPC_MSB:OPC_LSB]  = in_opcode;
    packed_word[RD_MSB:RD_LSB]    = in_rd;
    packed_word[FLAG_BIT]         = in_flag;
    case (in_fmt)
      FMT_REG: begin
        packed_word[RA_MSB:RA_LSB] = in_ra;
        packed_word[RB_MSB:RB_LSB] = in_rb;
      end
      FMT_IMM: packed_word[IMM_MSB:IMM_LSB] = in_imm;
      default: ;
    endcase
  end

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && !out_stall;

  instr_fifo #(
    .W     (INST_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (packed_word),
    .pop   (pop),
    .rdata (head_word),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output stage: latch head word on a pop, otherwise hold inst and drop the strobe
  always_comb begin
    inst_d    = inst_q;
    inst_wr_d = 1'b0;
    enc_cnt_d = enc_cnt_q;
    if (pop) begin
      inst_d    = head_word;
      inst_wr_d = 1'b1;
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
    end
  end

  // Output registers; reset drops any in-flight strobe immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q    <= '0;
      inst_wr_q <= 1'b0;
      enc_cnt_q <= '0;
    end else begin
      inst_q    <= inst_d;
      inst_wr_q <= inst_wr_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end

  assign inst      = inst_q;
  assign inst_wr   = inst_wr_q;
  assign enc_count = enc_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder. A queue-based reference model predicts the emitted
// words, the strobe and the counters cycle by cycle. Built with CNT_W = 4 so
// the word counter wraps quickly.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = 4;
  localparam int W     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_fmt;
  logic [3:0]       in_opcode;
  logic [2:0]       in_rd;
  logic             in_flag;
  logic [2:0]       in_ra;
  logic [2:0]       in_rb;
  logic [7:0]       in_imm;
  logic             out_stall;
  logic [W-1:0]     inst;
  logic             inst_wr;
  logic [PTR_W:0]   fifo_count;
  logic [CNT_W-1:0] enc_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_inst;
  logic         m_wr;
  int           m_enc;

  instr_encoder #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_flag    (in_flag),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_imm     (in_imm),
    .out_stall  (out_stall),
    .inst       (inst),
    .inst_wr    (inst_wr),
    .fifo_count (fifo_count),
    .enc_count  (enc_count)
  );

  // Clock
  always #5 clk = ~clk;

  // Instruction word from the field rules, by plain arithmetic
  function automatic logic [W-1:0] pack_ref(input logic fmt, input int opc, input int rd,
                                            input int flag, input int ra, input int rb,
                                            input int imm);
    int v;
    v = opc * 4096 + rd * 512 + flag * 256;
    if (fmt) v = v + imm;
    else     v = v + ra * 32 + rb * 4;
    return W'(v);
  endfunction

  // Driver helpers
  task automatic set_random_fields();
    in_fmt    = 1'($urandom_range(0, 1));
    in_opcode = 4'($urandom_range(0, 15));
    in_rd     = 3'($urandom_range(0, 7));
    in_flag   = 1'($urandom_range(0, 1));
    in_ra     = 3'($urandom_range(0, 7));
    in_rb     = 3'($urandom_range(0, 7));
    in_imm    = 8'($urandom_range(0, 255));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inst = '0;
    m_wr   = 1'b0;
    m_enc  = 0;
  endtask

  // Advance one clock: update the model from current inputs, return at the next negedge
  task automatic step();
    bit           do_push, do_pop;
    logic [W-1:0] w;
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = (exp_q.size() != 0) && !out_stall;
    w = pack_ref(in_fmt, int'(in_opcode), int'(in_rd), int'(in_flag),
                 int'(in_ra), int'(in_rb), int'(in_imm));
    @(posedge clk);
    if (do_pop) begin
      m_inst = exp_q.pop_front();
      m_wr   = 1'b1;
      m_enc  = (m_enc + 1) % (1 << CNT_W);
    end else begin
      m_wr = 1'b0;
    end
    if (do_push) exp_q.push_back(w);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_stall = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (inst !== 16'h0000) begin n_fail++; $display("FAIL reset_inst: got %h want 0000", inst); end
    n_checks++;
    if (inst_wr !== 1'b0) begin n_fail++; $display("FAIL reset_inst_wr: got %b want 0", inst_wr); end
    n_checks++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++;
    if (enc_count !== 4'd0) begin n_fail++; $display("FAIL reset_enc: got %0d want 0", enc_count); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reg_form();
    in_fmt = 1'b0; in_opcode = 4'h3; in_rd = 3'd5; in_flag = 1'b1;
    in_ra = 3'd2; in_rb = 3'd6; in_imm = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (inst_wr !== 1'b0) begin n_fail++; $display("FAIL reg_no_bypass: inst_wr got %b want 0", inst_wr); end
    n_checks++;
    if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL reg_count: got %0d want 1", fifo_count); end
    step();
    n_checks++;
    if (inst_wr !== 1'b1 || inst !== 16'h3B58) begin
      n_fail++; $display("FAIL reg_word: got wr=%b inst=%h want wr=1 inst=3B58", inst_wr, inst);
    end
    n_checks++;
    if (enc_count !== 4'd1) begin n_fail++; $display("FAIL reg_enc: got %0d want 1", enc_count); end
    step();
    n_checks++;
    if (inst_wr !== 1'b0 || inst !== 16'h3B58) begin
      n_fail++; $display("FAIL reg_one_shot: got wr=%b inst=%h want wr=0 inst=3B58", inst_wr, inst);
    end
  endtask

  task automatic test_imm_form();
    in_fmt = 1'b1; in_opcode = 4'hA; in_rd = 3'd7; in_flag = 1'b0; in_imm = 8'hC4;
    in_ra = 3'($urandom_range(0, 7)); in_rb = 3'($urandom_range(0, 7));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (inst_wr !== 1'b1 || inst !== 16'hAEC4) begin
      n_fail++; $display("FAIL imm_word: got wr=%b inst=%h want wr=1 inst=AEC4", inst_wr, inst);
    end
    step();
  endtask

  task automatic test_stall();
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_random_fields();
      in_valid = 1'b1;
      n_checks++;
      if (in_ready !== (exp_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b want %b", i, in_ready, exp_q.size() < DEPTH);
      end
      step();
      n_checks++;
      if (inst_wr !== 1'b0) begin n_fail++; $display("FAIL stall_no_wr[%0d]: got %b want 0", i, inst_wr); end
    end
    n_checks++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      n_fail++; $display("FAIL stall_full: got ready=%b count=%0d want ready=0 count=4", in_ready, fifo_count);
    end
    in_valid = 1'b0;
    step();
    out_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (inst_wr !== 1'b1 || inst !== m_inst) begin
        n_fail++; $display("FAIL stall_drain[%0d]: got wr=%b inst=%h want wr=1 inst=%h", i, inst_wr, inst, m_inst);
      end
    end
    n_checks++;
    if (int'(enc_count) != m_enc) begin n_fail++; $display("FAIL stall_enc: got %0d want %0d", enc_count, m_enc); end
    step();
    n_checks++;
    if (inst_wr !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL stall_empty: got wr=%b count=%0d want wr=0 count=0", inst_wr, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    out_stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin set_random_fields(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      step();
      n_checks++;
      if (fifo_count > 3'd1 || inst_wr !== m_wr || (m_wr && inst !== m_inst)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got count=%0d wr=%b inst=%h want count<=1 wr=%b inst=%h",
                 i, fifo_count, inst_wr, inst, m_wr, m_inst);
      end
    end
    n_checks++;
    if (int'(enc_count) != m_enc) begin n_fail++; $display("FAIL b2b_enc: got %0d want %0d", enc_count, m_enc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_random_fields();
      in_valid  = 1'($urandom_range(0, 1));
      out_stall = ($urandom_range(0, 3) == 0);
      n_checks++;
      if (in_ready !== (exp_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_q.size() < DEPTH);
      end
      step();
      n_checks++;
      if (inst_wr !== m_wr || inst !== m_inst || int'(fifo_count) != exp_q.size()
          || int'(enc_count) != m_enc) begin
        n_fail++;
        $display("FAIL rnd[%0d]: got wr=%b inst=%h cnt=%0d enc=%0d want wr=%b inst=%h cnt=%0d enc=%0d",
                 i, inst_wr, inst, fifo_count, enc_count, m_wr, m_inst, exp_q.size(), m_enc);
      end
    end
    in_valid = 1'b0;
    out_stall = 1'b0;
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_reset_mid();
    out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random_fields(); in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    out_stall = 1'b0;
    step();
    n_checks++;
    if (inst_wr !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wr: got %b want 1", inst_wr); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (inst_wr !== 1'b0 || fifo_count !== 3'd0 || inst !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset: got wr=%b count=%0d inst=%h want wr=0 count=0 inst=0000",
                         inst_wr, fifo_count, inst);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (inst_wr !== 1'b0 || fifo_count !== 3'd0) begin
        n_fail++; $display("FAIL mid_stale[%0d]: got wr=%b count=%0d want wr=0 count=0", i, inst_wr, fifo_count);
      end
    end
  endtask

  task automatic test_enc_wrap();
    int guard;
    out_stall = 1'b0;
    guard = 0;
    while (m_enc != (1 << CNT_W) - 1 && guard < 64) begin
      set_random_fields();
      in_valid = (exp_q.size() + m_enc < (1 << CNT_W) - 1);
      step();
      guard++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (int'(enc_count) != (1 << CNT_W) - 1) begin
      n_fail++; $display("FAIL wrap_pre: got %0d want %0d", enc_count, (1 << CNT_W) - 1);
    end
    set_random_fields();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (inst_wr !== 1'b1 || enc_count !== 4'd0 || inst !== m_inst) begin
      n_fail++; $display("FAIL wrap: got wr=%b enc=%0d inst=%h want wr=1 enc=0 inst=%h",
                         inst_wr, enc_count, inst, m_inst);
    end
  endtask

  // Test sequence
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_stall = 1'b0;
    set_random_fields();
    model_reset();
    test_reset();
    test_reg_form();
    test_imm_form();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_enc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Transmit-side counterpart of the instruction decoder: packs instruction fields into 16-bit words and delivers them on the decoder's `inst`/`inst_wr` write interface.
- A small FIFO decouples the field producer (test sequencer or loader) from a downstream consumer that can stall.
- Sits between the instruction source and the decoder / instruction memory write port.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- CNT_W, 16, width of the encoded-word counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set.
- in_fmt  in  1  0 = register form, 1 = immediate form.
- in_opcode  in  4  opcode.
- in_rd  in  3  destination register.
- in_flag  in  1  flag bit.
- in_ra  in  3  source A; register form only.
- in_rb  in  3  source B; register form only.
- in_imm  in  8  immediate; immediate form only.
- out_stall  in  1  consumer cannot take a word this cycle.
- inst  out  16  encoded instruction word.
- inst_wr  out  1  one-cycle write strobe for `inst`.
- fifo_count  out  PTR_W+1  current FIFO occupancy.
- enc_count  out  CNT_W  total words emitted on `inst_wr`.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state updates on the rising edge of clk.
- Reset values: inst = 0, inst_wr = 0, fifo_count = 0, enc_count = 0, read/write pointers = 0. in_ready = 1 after reset.
- Packing, register form (in_fmt = 0): word = {in_opcode, in_rd, in_flag, in_ra, in_rb, 2'b00}. in_imm is ignored.
- Packing, immediate form (in_fmt = 1): word = {in_opcode, in_rd, in_flag, in_imm}. in_ra and in_rb are ignored.
- Packing is combinational at the FIFO write side; the packed word is stored, not the raw fields.
- Input handshake:
  - in_ready = (fifo_count != DEPTH), combinational from registered count.
  - A push occurs on an edge where in_valid && in_ready.
  - Fields must be stable only during that cycle.
- Output stage is a registered pop:
  - On each edge, if fifo_count != 0 and out_stall = 0: inst <= head word, inst_wr <= 1, read pointer advances, enc_count increments.
  - Otherwise: inst_wr <= 0 and inst holds its last value.
- Latency: a set accepted at edge E can produce inst_wr = 1 at the earliest after edge E+1, i.e. 2 cycles. There is no bypass path.
- Throughput: one word per cycle when not stalled.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Full: in_ready = 0; in_valid is ignored and nothing is overwritten.
- Empty: inst_wr = 0; inst is not modified.
- Stall: only the pop is suppressed. Pushes continue until full.
- Wrap-around:
  - Pointers wrap modulo DEPTH.
  - enc_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: FIFO contents are discarded (occupancy = 0) and any inst_wr in flight drops immediately.
- No state machine beyond FIFO control; no X propagation on unused fields.

Decomposition:
- Shared package `instr_pkg` holds:
  - field positions: OPC_MSB=15, OPC_LSB=12, RD 11:9, FLAG 8, RA 7:5, RB 4:2, IMM 7:0;
  - FMT_REG=0, FMT_IMM=1;
  - INST_W=16.
- The decoder is to share the same package.
- One natural sub-module: `instr_fifo`, a parameterised sync FIFO with push, pop, count, full and empty. Packing logic and the output register stay in `instr_encoder`.

Test Plan:
- Reset, then fmt=0, opc=4'h3, rd=5, flag=1, ra=2, rb=6, single push, out_stall=0 -> inst = 16'h3B58 with inst_wr high for exactly one cycle, 2 cycles after accept; enc_count = 1.
- fmt=1, opc=4'hA, rd=7, flag=0, imm=8'hC4 (ra/rb randomised) -> inst = 16'hAEC4, bits unaffected by ra/rb.
- out_stall=1, push 5 sets back-to-back -> 4 accepted, in_ready low on the 5th, fifo_count = 4, inst_wr stays 0. Release stall -> 4 words in order on consecutive cycles, enc_count = 4.
- Continuous push with out_stall=0 for 10 words -> fifo_count stays ≤ 1, one inst_wr per cycle, pointers wrap correctly, order preserved.
- Fill 3 entries, assert reset mid-drain -> inst_wr = 0, fifo_count = 0, inst = 0 immediately. No stale word emitted after reset release.
- Preload enc_count near wrap (via 2^CNT_W-1 pops, or CNT_W=4 build) -> next emission reads enc_count = 0.
